// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the radix-8 Booth multiplier family
// (the sequential booth8_mult_seq and the planned parallel variant).
package mult_pkg;

    localparam int GRP_W = 3;

    // Number of radix-8 digits needed to cover bits+1 multiplier bits: ceil((bits+1)/3)
    function automatic int ngrp_f(input int bits);
        return (bits + GRP_W) / GRP_W;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // mag is one-hot {4M, 3M, 2M, 1M}; all-zero selects 0. neg requests two's-complement negation.
    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
    } booth_sel_t;

endpackage

// File: rtl/booth8_digit_dec.sv
// Radix-8 Booth digit decoder: overlapping 4-bit multiplier group to
// multiple select plus negate. Purely combinational.
module booth8_digit_dec
    import mult_pkg::*;
(
    input  logic [3:0] grp,
    output booth_sel_t sel
);

    always_comb begin
        sel = '{neg: 1'b0, mag: 4'b0000};
        unique case (grp)
            4'b0000, 4'b1111: sel = '{neg: 1'b0, mag: 4'b0000};
            4'b0001, 4'b0010: sel = '{neg: 1'b0, mag: 4'b0001};
            4'b0011, 4'b0100: sel = '{neg: 1'b0, mag: 4'b0010};
            4'b0101, 4'b0110: sel = '{neg: 1'b0, mag: 4'b0100};
            4'b0111:          sel = '{neg: 1'b0, mag: 4'b1000};
            4'b1000:          sel = '{neg: 1'b1, mag: 4'b1000};
            4'b1001, 4'b1010: sel = '{neg: 1'b1, mag: 4'b0100};
            4'b1011, 4'b1100: sel = '{neg: 1'b1, mag: 4'b0010};
            4'b1101, 4'b1110: sel = '{neg: 1'b1, mag: 4'b0001};
            default:          sel = '{neg: 1'b0, mag: 4'b0000};
        endcase
    end

endmodule

// File: rtl/booth8_mult_seq.sv
// Sequential radix-8 Booth multiplier, one digit per clock.
// Define MULT_SIGNED_EN to add the iSigned input for two's-complement operands.
//
// state | meaning
// IDLE  | waiting for iStart; operands captured on accepted start
// PREP  | build hard multiple 3M, clear accumulator and digit counter
// ITER  | accumulate one shifted partial product per cycle
// DONE  | oDone pulse, oZ valid
module booth8_mult_seq
    import mult_pkg::*;
#(
    parameter int Bits = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic              iAbort,
`ifdef MULT_SIGNED_EN
    input  logic              iSigned,
`endif
    input  logic [Bits-1:0]   iM,
    input  logic [Bits-1:0]   iQ,
    output logic              oBusy,
    output logic              oDone,
    output logic [2*Bits-1:0] oZ
);

    localparam int NGRP  = ngrp_f(Bits);
    localparam int QEXT  = GRP_W * NGRP;
    localparam int MREGW = Bits + 2;
    localparam int MW    = Bits + 4;     // wide enough for +/-4M with sign
    localparam int AW    = 2 * Bits + 4;
    localparam int CNT_W = $clog2(NGRP);
    localparam int SH_W  = $clog2(AW);

    state_t state, state_nx;

    logic [MREGW-1:0]  m_reg;
    logic [MW-1:0]     m3_reg;
    logic [QEXT:0]     qx_reg;
    logic [AW-1:0]     acc;
    logic [CNT_W-1:0]  cnt;
    logic [2*Bits-1:0] z_reg;

    logic cap_en, prep_en, iter_en, last_en;
    logic cnt_last;
    logic m_sgn, q_sgn;

    logic [SH_W-1:0] sh_amt;
    logic [3:0]      grp;
    booth_sel_t      sel;
    logic [MW-1:0]   m_ext;
    logic [MW-1:0]   pp_mag;
    logic [MW-1:0]   pp;
    logic [AW-1:0]   pp_acc;
    logic [AW-1:0]   acc_next;

`ifdef MULT_SIGNED_EN
    assign m_sgn = iSigned & iM[Bits-1];
    assign q_sgn = iSigned & iQ[Bits-1];
`else
    assign m_sgn = 1'b0;
    assign q_sgn = 1'b0;
`endif

    assign cnt_last = (cnt == CNT_W'(NGRP - 1));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cap_en   = 1'b0;
        prep_en  = 1'b0;
        iter_en  = 1'b0;
        last_en  = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    cap_en   = 1'b1;
                    state_nx = PREP;
                end
            end
            PREP: begin
                if (iAbort) begin
                    state_nx = IDLE;
                end else begin
                    prep_en  = 1'b1;
                    state_nx = ITER;
                end
            end
            ITER: begin
                if (iAbort) begin
                    state_nx = IDLE;
                end else begin
                    iter_en = 1'b1;
                    if (cnt_last) begin
                        last_en  = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Group k sits at Qx[3k+3:3k]; the same amount shifts the partial product.
    assign sh_amt = SH_W'(cnt) * SH_W'(GRP_W);
    assign grp    = 4'(qx_reg >> sh_amt);

    booth8_digit_dec u_dec (
        .grp (grp),
        .sel (sel)
    );

    assign m_ext  = {{(MW - MREGW){m_reg[MREGW-1]}}, m_reg};
    assign pp_mag = ({MW{sel.mag[0]}} & m_ext)
                  | ({MW{sel.mag[1]}} & (m_ext << 1))
                  | ({MW{sel.mag[2]}} & m3_reg)
                  | ({MW{sel.mag[3]}} & (m_ext << 2));
    assign pp       = sel.neg ? (~pp_mag + MW'(1)) : pp_mag;
    assign pp_acc   = {{(AW - MW){pp[MW-1]}}, pp} << sh_amt;
    assign acc_next = acc + pp_acc;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            m_reg  <= '0;
            m3_reg <= '0;
            qx_reg <= '0;
            acc    <= '0;
            cnt    <= '0;
            z_reg  <= '0;
        end else begin
            if (cap_en) begin
                m_reg  <= {{(MREGW - Bits){m_sgn}}, iM};
                qx_reg <= {{(QEXT - Bits){q_sgn}}, iQ, 1'b0};
            end
            if (prep_en) begin
                m3_reg <= m_ext + (m_ext << 1);
                acc    <= '0;
                cnt    <= '0;
            end
            if (iter_en) begin
                acc <= acc_next;
                if (!cnt_last) cnt <= cnt + CNT_W'(1);
            end
            // Upper acc bits are sign/guard only; the product is the low 2*Bits.
            if (last_en) z_reg <= acc_next[2*Bits-1:0];
        end
    end

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);
    assign oZ    = z_reg;

endmodule
